// File: rtl/ks_arb_pkg.sv
// Shared types and constants for the two-requester Kogge-Stone add sequencer.
// Optional subtract support is enabled with the KS_ARB_SUB_EN macro.
package ks_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NBYTES_DEF = 4;

    // Byte index width, kept at least one bit wide for single-byte builds
    function automatic int kw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int KW_DEF = kw_of(NBYTES_DEF);

endpackage

// File: rtl/ks_adder8_core.sv
// Combinational 8-bit Kogge-Stone adder: three prefix levels (span 1, 2, 4).
// Carry-in is folded into the bit-0 generate so the prefix yields every carry.
module ks_adder8_core (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] p;
    logic [7:0] g0;
    logic [7:0] g1;
    logic [7:0] p1;
    logic [7:0] g2;
    logic [7:0] p2;
    logic [7:0] g3;

    assign p  = a ^ b;
    assign g0 = (a & b) | {7'b0, p[0] & cin};

    assign g1 = g0 | (p & {g0[6:0], 1'b0});
    assign p1 = p & {p[6:0], 1'b1};

    assign g2 = g1 | (p1 & {g1[5:0], 2'b0});
    assign p2 = p1 & {p1[5:0], 2'b11};

    assign g3 = g2 | (p2 & {g2[3:0], 4'b0});

    assign sum  = p ^ {g3[6:0], cin};
    assign cout = g3[7];

endmodule

// File: rtl/ks_add_arbiter.sv
// Round-robin arbiter and LSB-first byte sequencer around one 8-bit KS adder.
// Define KS_ARB_SUB_EN to add the per-requester req_sub (subtract) input.
module ks_add_arbiter
    import ks_arb_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [8*NBYTES-1:0] req_a0,
    input  logic [8*NBYTES-1:0] req_b0,
    input  logic [8*NBYTES-1:0] req_a1,
    input  logic [8*NBYTES-1:0] req_b1,
    input  logic [1:0]          req_cin,
`ifdef KS_ARB_SUB_EN
    input  logic [1:0]          req_sub,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [8*NBYTES-1:0] rsp_sum,
    output logic                rsp_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = kw_of(NBYTES);
    localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

    state_t state;
    state_t state_next;

    logic          last_grant;
    logic          gsel;
    logic          accept;
    logic          id_lat;
    logic          carry;
    logic [KW-1:0] k;
    logic [KW+2:0] bofs;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic [W-1:0]  sum_lat;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          c_in;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [7:0]    s_byte;
    logic          c_byte;

    // Tie goes to the requester that did not win last time
    always_comb begin
        gsel = req_valid[1];
        if (req_valid == 2'b11) begin
            gsel = ~last_grant;
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (rst_n && ena && (state == IDLE)) begin
            req_ready[gsel] = req_valid[gsel];
        end
    end

    assign accept = |req_ready;

    always_comb begin
        a_in = gsel ? req_a1 : req_a0;
        b_in = gsel ? req_b1 : req_b0;
        c_in = req_cin[gsel];
`ifdef KS_ARB_SUB_EN
        if (req_sub[gsel]) begin
            b_in = ~b_in;
            c_in = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (k == KLAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bofs   = {k, 3'b000};
    assign a_byte = a_lat[bofs +: 8];
    assign b_byte = b_lat[bofs +: 8];

    ks_adder8_core u_core (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .sum  (s_byte),
        .cout (c_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_lat     <= 1'b0;
            carry      <= 1'b0;
            k          <= '0;
            a_lat      <= '0;
            b_lat      <= '0;
            sum_lat    <= '0;
        end else if (ena) begin
            state <= state_next;
            if (accept) begin
                a_lat      <= a_in;
                b_lat      <= b_in;
                carry      <= c_in;
                id_lat     <= gsel;
                last_grant <= gsel;
                k          <= '0;
            end
            if (state == RUN) begin
                sum_lat[bofs +: 8] <= s_byte;
                carry              <= c_byte;
                if (k != KLAST) begin
                    k <= k + 1'b1;
                end
            end
        end
    end

    // After the last byte the carry register holds the top-byte carry out
    assign rsp_valid = (state == DONE);
    assign rsp_id    = id_lat;
    assign rsp_sum   = sum_lat;
    assign rsp_cout  = carry;

endmodule

// File: doc/ks_add_arbiter.md
# ks_add_arbiter

Two-requester arbiter and sequencer for a shared 8-bit Kogge-Stone adder core. It accepts multi-byte add requests from two clients and grants them round-robin. Each granted operation runs LSB-first, one byte per cycle, through the single adder with a registered carry chain. It sits between the tile's control logic and the adder datapath, so wide additions reuse one 8-bit carry-lookahead slice.

## Interface
Parameters:
- NBYTES, 4, operand/result width in bytes (1..8); W = 8*NBYTES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  global enable; low freezes all state.
- req_valid  in  2  request valid, bit r for requester r.
- req_ready  out  2  request accepted this cycle (one-hot or zero).
- req_a0, req_b0  in  W  requester 0 operands.
- req_a1, req_b1  in  W  requester 1 operands.
- req_cin  in  2  carry-in per requester.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that owns the result.
- rsp_sum  out  W  sum.
- rsp_cout  out  1  carry out of the top byte.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready[g] = ena & req_valid[g] for the granted g; otherwise 0.
  - Grant rule: a single requester wins. If both request, grant goes to !last_grant.
  - On handshake: latch operands, cin, and id = g; set byte index k = 0; last_grant <= g; go to RUN.
- RUN:
  - Each cycle, drive adder with a_lat[8k+7:8k], b_lat[8k+7:8k], carry_reg (initialised to cin). Write sum byte k and update carry_reg.
  - When k = NBYTES-1, go to DONE.
- DONE:
  - rsp_valid = 1; rsp_sum, rsp_cout, rsp_id are stable.
  - On rsp_valid & rsp_ready, go to IDLE.
- Only IDLE asserts req_ready, so there are no overlapping operations.
- Requests not granted stay pending. req_valid may drop before grant without error.
- Operands are captured at handshake; later changes to req_a*/req_b* have no effect.
- ena = 0: FSM, k, carry, and registers hold; req_ready = 0; rsp_valid holds its value. A response handshake does not complete while ena = 0.
- Arithmetic: result is modulo 2^W; rsp_cout = bit W of a + b + cin.

## Timing
- Reset (rst_n low at an edge): state IDLE, last_grant = 1 so requester 0 wins the first tie; k = 0; carry = 0.
- Outputs during reset: rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, req_ready = 0.
- Latency: with the accept at edge t, rsp_valid is first high after edge t+NBYTES, given continuous ena.
- Throughput: one operation per NBYTES+2 cycles (accept, NBYTES run cycles, response).
- rsp_ready high at first DONE cycle: IDLE next cycle; a new grant is possible in that IDLE cycle.
- Reset mid RUN/DONE: operation is discarded, no response is produced, and the block is in IDLE next cycle.
- req_ready is combinational from req_valid, state, and last_grant. No other output is combinational from inputs.

## Configuration
- KS_ARB_SUB_EN defined:
  - Adds input req_sub (2 bits).
  - For a subtract request, b is inverted byte-wise and carry is initialised to 1; req_cin is ignored.
  - rsp_cout = 1 means no borrow.
- KS_ARB_SUB_EN undefined: req_sub port is absent; add only.

## Structure
- Package ks_arb_pkg:
  - state enum {IDLE, RUN, DONE};
  - NBYTES default constant;
  - byte index width constant clog2(NBYTES).
- Sub-module ks_adder8_core:
  - combinational 8-bit Kogge-Stone adder with a, b, cin, sum, cout;
  - three prefix levels;
  - instantiated once.
- The top holds the FSM, arbiter, operand/result registers, and carry register.

## Test plan
- Req0, a=0x000000FF, b=0x00000001, cin=0 -> rsp_sum=0x00000100, cout=0, id=0, rsp_valid first high 4 cycles after accept.
- Req1, a=0xFFFFFFFF, b=0x00000001, cin=0 -> rsp_sum=0x00000000, cout=1, id=1. Also cin=1 with a=b=0 -> sum=0x00000001.
- Both req_valid high continuously after reset -> grants in order 0,1,0,1; req_ready is never both bits set.
- rsp_ready held low for 3 cycles in DONE -> rsp_valid/rsp_sum stable, req_ready=0. rsp_ready=1 -> IDLE next cycle.
- rst_n low for one edge during RUN (k=2) -> rsp_valid never rises; IDLE; next request returns a correct sum.
- ena low for 2 cycles mid RUN -> latency becomes 6, sum still correct. With KS_ARB_SUB_EN: 0x00000005 - 0x00000007 -> 0xFFFFFFFE, cout=0.
